// File: rtl/multi_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer_if
// Purpose  : CPU data-bus bundle used by multi_timer: write data, byte
//            address and write enable. The read-data return path (Datain)
//            is a plain port on the peripheral because it is tri-stated
//            onto the shared bus.
// Signals  : Dataout [31:0] CPU write data
//            address [31:0] CPU byte address
//            WE             CPU write enable, sampled on clk
// Modports : master (CPU side, drives), slave (peripheral side, samples)
// Revision : 1.0 - initial release
// ============================================================================
interface multi_timer_if;
    logic [31:0] Dataout;
    logic [31:0] address;
    logic        WE;

    modport master (output Dataout, output address, output WE);
    modport slave  (input  Dataout, input  address, input  WE);
endinterface
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer
// Purpose  : Memory-mapped multi-channel interval timer. Each channel has a
//            CTRL word (START/DONE/MODE/SRC/BUSY/STOP/IE) and a PERIOD word,
//            counts to a terminal value T taken from PERIOD or from a
//            switch-selected table, and raises a sticky DONE flag.
// Ports    : clk      system clock, rising edge
//            rst      asynchronous active-low reset
//            sw[1:0]  period table select for channels with SRC=1
//            bus      CPU write bus (Dataout/address/WE), slave modport
//            Datain   CPU read data, high-Z outside the register window
//            irq      per-channel DONE & IE, registered
// Revision : 1.0 - initial release
// ============================================================================
module multi_timer #(
    parameter int          N_CH      = 2,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h110,
    parameter int          CLK_HZ    = 100_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      sw,
    multi_timer_if.slave    bus,
    output logic [31:0]     Datain,
    output logic [N_CH-1:0] irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    // Switch table terminal values, computed wide and truncated to CNT_W.
    localparam logic [63:0]      c_hz   = 64'(CLK_HZ);
    localparam logic [CNT_W-1:0] c_tab0 = CNT_W'(c_hz / 64'd2 - 64'd1);
    localparam logic [CNT_W-1:0] c_tab1 = CNT_W'(c_hz - 64'd1);
    localparam logic [CNT_W-1:0] c_tab2 = CNT_W'(c_hz * 64'd2 - 64'd1);
    localparam logic [CNT_W-1:0] c_tab3 = CNT_W'(c_hz * 64'd4 - 64'd1);
    localparam logic [31:0]      c_win  = 32'(8 * N_CH);

    logic [31:0]      w_off;
    logic             w_hit;
    logic [2:0]       w_ch;
    logic             w_sel;
    logic [CNT_W-1:0] w_table;
    logic [31:0]      w_rdata;
    logic [31:0]      w_ctrl_rd [N_CH];
    logic [31:0]      w_per_rd  [N_CH];
    logic             w_unused;

    // Addresses below BASE_ADDR wrap to large offsets and fall outside the
    // window, so a single unsigned compare covers both ends.
    assign w_off = bus.address - BASE_ADDR;
    assign w_hit = (w_off < c_win) && (bus.address[1:0] == 2'b00);
    assign w_ch  = w_off[5:3];
    assign w_sel = w_off[2];

    assign w_unused = ^{bus.Dataout[31:7], bus.Dataout[4]};

    always_comb begin
        w_table = c_tab0;
        case (sw)
            2'd0:    w_table = c_tab0;
            2'd1:    w_table = c_tab1;
            2'd2:    w_table = c_tab2;
            default: w_table = c_tab3;
        endcase
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        state_t           r_state, w_state_nxt;
        logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
        logic [CNT_W-1:0] r_term, w_term_nxt;
        logic [CNT_W-1:0] r_period, w_src_t;
        logic             r_done, w_done_nxt;
        logic             r_mode, r_src, r_ie, r_irq;
        logic             w_sel_ch, w_wr_ctrl, w_wr_per;
        logic             w_start, w_stop, w_w1c, w_busy;

        assign w_sel_ch  = bus.WE && w_hit && (w_ch == 3'(gi));
        assign w_wr_ctrl = w_sel_ch && !w_sel;
        assign w_wr_per  = w_sel_ch &&  w_sel;
        assign w_start   = w_wr_ctrl && bus.Dataout[0];
        assign w_stop    = w_wr_ctrl && bus.Dataout[5];
        assign w_w1c     = w_wr_ctrl && bus.Dataout[1];
        assign w_busy    = (r_state != ST_IDLE);
        assign w_src_t   = r_src ? w_table : r_period;

        // STOP beats START, and both pre-empt whatever the counter would
        // have done this edge. A hardware DONE set beats a W1C.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_term_nxt  = r_term;
            w_done_nxt  = r_done;
            if (w_w1c) begin
                w_done_nxt = 1'b0;
            end
            if (w_stop) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else if (w_start) begin
                w_state_nxt = ST_LOAD;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        w_term_nxt  = w_src_t;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_COUNT;
                    end
                    ST_COUNT: begin
                        if (r_cnt == r_term) begin
                            w_done_nxt = 1'b1;
                            w_cnt_nxt  = '0;
                            if (r_mode) begin
                                w_term_nxt = w_src_t;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_term  <= '0;
                r_done  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_term  <= w_term_nxt;
                r_done  <= w_done_nxt;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_mode   <= 1'b0;
                r_src    <= 1'b0;
                r_ie     <= 1'b0;
                r_period <= '0;
                r_irq    <= 1'b0;
            end else begin
                if (w_wr_ctrl) begin
                    r_mode <= bus.Dataout[2];
                    r_src  <= bus.Dataout[3];
                    r_ie   <= bus.Dataout[6];
                end
                if (w_wr_per) begin
                    r_period <= CNT_W'(bus.Dataout);
                end
                r_irq <= r_done && r_ie;
            end
        end

        assign w_ctrl_rd[gi] = {25'd0, r_ie, 1'b0, w_busy, r_src, r_mode, r_done, 1'b0};
        assign w_per_rd[gi]  = 32'(r_period);
        assign irq[gi]       = r_irq;
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch == 3'(i)) begin
                w_rdata = w_sel ? w_per_rd[i] : w_ctrl_rd[i];
            end
        end
    end

    assign Datain = w_hit ? w_rdata : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_timer
// Purpose  : Directed bench for multi_timer (2 channels, CLK_HZ=8). A
//            timestamp-based model predicts DONE edges, register contents
//            and irq; literal expectations pin key points of the sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_timer;
    localparam int          TB_CLK_HZ = 8;
    localparam logic [31:0] TB_BASE   = 32'h110;

    logic        clk;
    logic        rst;
    logic [1:0]  sw;
    wire  [31:0] Datain;
    logic [1:0]  irq;

    multi_timer_if bus ();

    multi_timer #(
        .N_CH      (2),
        .CNT_W     (32),
        .BASE_ADDR (TB_BASE),
        .CLK_HZ    (TB_CLK_HZ)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .bus    (bus),
        .Datain (Datain),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A released bus reads Z; a two-state simulator resolves that to 0.
    task automatic chkz(input string name);
        checks++;
        if (!(Datain === 32'bz || Datain === 32'h0)) begin
            failures++;
            $display("FAIL %s: got %h expected high-Z (t=%0t)", name, Datain, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint      cyc = 0;
    bit          m_active  [2];
    longint      m_load_at [2];
    longint      m_fire_at [2];
    bit          m_mode [2], m_src [2], m_ie [2], m_done [2], m_irq [2];
    logic [31:0] m_period [2];

    function automatic longint src_t(input int c);
        if (m_src[c]) return ((longint'(TB_CLK_HZ)) << sw) / 2 - 1;
        return longint'(m_period[c]);
    endfunction

    always @(posedge clk) begin
        logic [31:0] a, off;
        bit          hit, wc, wp, fire;
        cyc++;
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                m_active[c] = 0; m_load_at[c] = -1; m_fire_at[c] = -1;
                m_mode[c] = 0; m_src[c] = 0; m_ie[c] = 0; m_done[c] = 0;
                m_irq[c] = 0; m_period[c] = '0;
            end
        end else begin
            a   = bus.address;
            off = a - TB_BASE;
            hit = (a[1:0] == 2'b00) && (a >= TB_BASE) && (a < TB_BASE + 32'd16);
            for (int c = 0; c < 2; c++) begin
                wc   = bus.WE && hit && (off / 8 == c) && (off % 8 == 0);
                wp   = bus.WE && hit && (off / 8 == c) && (off % 8 == 4);
                fire = 0;
                m_irq[c] = m_done[c] & m_ie[c];
                if (wc && bus.Dataout[5]) begin
                    m_active[c] = 0;
                end else if (wc && bus.Dataout[0]) begin
                    m_active[c]  = 1;
                    m_load_at[c] = cyc + 1;
                    m_fire_at[c] = -1;
                end else if (m_active[c]) begin
                    if (cyc == m_load_at[c]) begin
                        m_fire_at[c] = cyc + src_t(c) + 1;
                    end else if (cyc == m_fire_at[c]) begin
                        fire = 1;
                        if (m_mode[c]) m_fire_at[c] = cyc + src_t(c) + 1;
                        else           m_active[c]  = 0;
                    end
                end
                if (fire)                        m_done[c] = 1;
                else if (wc && bus.Dataout[1])   m_done[c] = 0;
                if (wc) begin
                    m_mode[c] = bus.Dataout[2];
                    m_src[c]  = bus.Dataout[3];
                    m_ie[c]   = bus.Dataout[6];
                end
                if (wp) m_period[c] = bus.Dataout;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        logic [31:0] a, off, ev;
        int          c;
        #1;
        a   = bus.address;
        off = a - TB_BASE;
        if ((a[1:0] == 2'b00) && (a >= TB_BASE) && (a < TB_BASE + 32'd16)) begin
            c = int'(off / 8);
            if (off % 8 == 4) ev = m_period[c];
            else ev = {25'd0, m_ie[c], 1'b0, m_active[c], m_src[c], m_mode[c], m_done[c], 1'b0};
            chk32("model_datain", Datain, ev);
        end else begin
            chkz("model_datain_z");
        end
        chk32("model_irq", {30'd0, irq}, {30'd0, m_irq[1], m_irq[0]});
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.address = a;
        bus.Dataout = d;
        bus.WE      = 1'b1;
        @(negedge clk);
        bus.WE      = 1'b0;
        bus.Dataout = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.address = a;
        #1;
        chk32(name, Datain, exp);
    endtask

    task automatic rdz(input logic [31:0] a, input string name);
        bus.address = a;
        #1;
        chkz(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        sw          = 2'd0;
        bus.address = TB_BASE;
        bus.Dataout = '0;
        bus.WE      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rd(32'h110, 32'h0, "reset_ctrl0");
        chk32("reset_irq", {30'd0, irq}, 32'h0);
        @(negedge clk);

        // One-shot, PERIOD=5: DONE at E+7, irq at E+8.
        wr(32'h114, 32'd5);
        wr(32'h110, 32'h41);
        chk32("os_busy", Datain, 32'h50);
        repeat (6) @(negedge clk);
        chk32("os_e6", Datain, 32'h50);
        @(negedge clk);
        chk32("os_done_e7", Datain, 32'h42);
        chk32("os_irq_e7", {30'd0, irq}, 32'h0);
        @(negedge clk);
        chk32("os_irq_e8", {30'd0, irq}, 32'h1);
        repeat (10) @(negedge clk);
        chk32("os_idle", Datain, 32'h42);
        wr(32'h110, 32'h42);
        repeat (5) @(negedge clk);
        chk32("os_no_refire", Datain, 32'h40);
        chk32("os_irq_clr", {30'd0, irq}, 32'h0);

        // Periodic, PERIOD=3: DONE at E+5, E+9, E+13.
        wr(32'h114, 32'd3);
        wr(32'h110, 32'h45);
        repeat (4) @(negedge clk);
        chk32("per_e4", Datain, 32'h54);
        @(negedge clk);
        chk32("per_e5", Datain, 32'h56);
        repeat (3) @(negedge clk);
        wr(32'h110, 32'h06);
        chk32("per_set_wins", Datain, 32'h16);
        wr(32'h110, 32'h06);
        chk32("per_w1c", Datain, 32'h14);
        repeat (3) @(negedge clk);
        chk32("per_e13", Datain, 32'h16);
        wr(32'h110, 32'h20);
        chk32("per_stop", Datain, 32'h02);

        // Switch source, sw=2 -> T=15, DONE at E+17; sw=1 applies at wrap.
        sw = 2'd2;
        wr(32'h110, 32'h0F);
        chk32("sw_start", Datain, 32'h1C);
        repeat (5) @(negedge clk);
        sw = 2'd1;
        repeat (11) @(negedge clk);
        chk32("sw_e16", Datain, 32'h1C);
        @(negedge clk);
        chk32("sw_e17", Datain, 32'h1E);
        wr(32'h110, 32'h0E);
        chk32("sw_w1c", Datain, 32'h1C);
        repeat (6) @(negedge clk);
        chk32("sw_e24", Datain, 32'h1C);
        @(negedge clk);
        chk32("sw_e25", Datain, 32'h1E);
        wr(32'h110, 32'h20);
        sw = 2'd0;

        // Two channels, START+STOP, restart while busy.
        wr(32'h114, 32'd2);
        wr(32'h11C, 32'd9);
        wr(32'h110, 32'h47);
        wr(32'h118, 32'h45);
        chk32("ch1_start", Datain, 32'h54);
        repeat (10) @(negedge clk);
        chk32("ch1_e10", Datain, 32'h54);
        @(negedge clk);
        chk32("ch1_e11", Datain, 32'h56);
        wr(32'h118, 32'h21);
        chk32("ch1_startstop", Datain, 32'h02);
        wr(32'h110, 32'h47);
        chk32("restart", Datain, 32'h54);
        repeat (2) @(negedge clk);
        chk32("restart_e2", Datain, 32'h54);
        @(negedge clk);
        chk32("restart_e3", Datain, 32'h54);
        @(negedge clk);
        chk32("restart_e4", Datain, 32'h56);
        wr(32'h110, 32'h20);
        rd(32'h118, 32'h02, "ch1_still_idle");

        // Ignored accesses.
        @(negedge clk);
        wr(32'h111, 32'h4D);
        wr(32'h120, 32'h4D);
        wr(32'h115, 32'd7);
        repeat (5) @(negedge clk);
        rd(32'h110, 32'h02, "ign_ctrl0");
        rd(32'h114, 32'd2, "ign_period0");
        rdz(32'h111, "ign_misaligned_z");
        rdz(32'h120, "ign_outside_z");
        @(negedge clk);

        // Reset mid-count.
        wr(32'h114, 32'd5);
        wr(32'h110, 32'h41);
        repeat (3) @(negedge clk);
        chk32("rst_pre_irq", {30'd0, irq}, 32'h1);
        rst = 1'b0;
        #1;
        chk32("rst_async_ctrl", Datain, 32'h0);
        chk32("rst_async_irq", {30'd0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd(32'h114, 32'h0, "rst_period0");
        rdz(32'h200, "rst_z_200");
        bus.address = 32'h110;
        repeat (10) @(negedge clk);
        chk32("rst_no_done", Datain, 32'h0);
        chk32("rst_irq_end", {30'd0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
